// File: rtl/microsequencer.sv
// Micro-state sequencer for the multicycle MIPS control unit: selects the next
// microprogram address (fetch / dispatch 1 / dispatch 2 / +1) and tracks errors.
// Optional performance counters are enabled with `define USEQ_PERF_EN.
module microsequencer #(
  parameter int STATE_W    = 4,
  parameter int NUM_STATES = 10
`ifdef USEQ_PERF_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [1:0]         addrctl,
  input  logic               stall,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               bad_state
`ifdef USEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  typedef enum logic [1:0] {
    AC_FETCH = 2'b00,
    AC_DISP1 = 2'b01,
    AC_DISP2 = 2'b10,
    AC_SEQ   = 2'b11
  } addrctl_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;

  typedef enum logic [STATE_W-1:0] {
    US_FETCH  = 0,
    US_DECODE = 1,
    US_MEMADR = 2,
    US_MEMRD  = 3,
    US_MEMWB  = 4,
    US_MEMWR  = 5,
    US_EXEC   = 6,
    US_ALUWB  = 7,
    US_BRANCH = 8,
    US_JUMP   = 9
  } ustate_t;

  localparam logic [STATE_W:0] LIMIT = NUM_STATES[STATE_W:0];

  addrctl_t           ac;
  logic [STATE_W:0]   state_x;
  logic [STATE_W:0]   seq_inc;
  logic [STATE_W-1:0] nxt;
  logic               done_nxt;
  logic               ill_set;
  logic               bad_set;

  assign ac      = addrctl_t'(addrctl);
  assign state_x = {1'b0, state};
  assign seq_inc = state_x + {{STATE_W{1'b0}}, 1'b1};

  always_comb begin
    nxt      = state;
    done_nxt = 1'b0;
    ill_set  = 1'b0;
    bad_set  = 1'b0;
    if (state_x >= LIMIT) begin
      nxt     = US_FETCH;
      bad_set = 1'b1;
    end else begin
      case (ac)
        AC_FETCH: begin
          nxt      = US_FETCH;
          // Only a legitimate return from a non-fetch state completes an instruction
          done_nxt = (state != '0);
        end
        AC_SEQ: begin
          if (seq_inc >= LIMIT) begin
            nxt     = US_FETCH;
            bad_set = 1'b1;
          end else begin
            nxt = seq_inc[STATE_W-1:0];
          end
        end
        AC_DISP1: begin
          case (opcode)
            OP_RTYPE:     nxt = US_EXEC;
            OP_LW, OP_SW: nxt = US_MEMADR;
            OP_BEQ:       nxt = US_BRANCH;
            OP_J:         nxt = US_JUMP;
            default: begin
              nxt     = US_FETCH;
              ill_set = 1'b1;
            end
          endcase
        end
        AC_DISP2: begin
          case (opcode)
            OP_LW:   nxt = US_MEMRD;
            OP_SW:   nxt = US_MEMWR;
            default: begin
              nxt     = US_FETCH;
              ill_set = 1'b1;
            end
          endcase
        end
        default: nxt = US_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= '0;
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
      bad_state  <= 1'b0;
    end else if (stall) begin
      instr_done <= 1'b0;
    end else begin
      state      <= nxt;
      instr_done <= done_nxt;
      illegal_op <= illegal_op | ill_set;
      bad_state  <= bad_state | bad_set;
    end
  end

`ifdef USEQ_PERF_EN
  // instr_cnt advances on the same edge that raises instr_done, so it already
  // includes the instruction whose completion pulse is currently visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (!stall && done_nxt)
        instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed vector table, perf-counter sequences
// (when USEQ_PERF_EN is defined) and randomized run against a reference model.
module tb_microsequencer;

  localparam int NUM = 10;
`ifdef USEQ_PERF_EN
  localparam int CW  = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [1:0] addrctl = '0;
  logic       stall = 1'b0;
  logic [3:0] state;
  logic       instr_done, illegal_op, bad_state;
`ifdef USEQ_PERF_EN
  logic [CW-1:0] cycle_cnt, instr_cnt;
`endif

  microsequencer #(
    .STATE_W(4),
    .NUM_STATES(NUM)
`ifdef USEQ_PERF_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .addrctl(addrctl),
    .stall(stall),
    .state(state),
    .instr_done(instr_done),
    .illegal_op(illegal_op),
    .bad_state(bad_state)
`ifdef USEQ_PERF_EN
    , .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state
  int m_st = 0;
  bit m_dn = 0, m_il = 0, m_bd = 0;
  int m_cyc = 0, m_ins = 0;
  int d1[int];
  int d2[int];

  typedef struct {
    logic       rst;
    logic       stl;
    logic [1:0] ac;
    logic [5:0] op;
    int         st;
    logic       dn;
    logic       il;
    logic       bd;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic rst, logic stl, logic [1:0] ac, logic [5:0] op,
                              int st, logic dn, logic il, logic bd);
    vec_t v;
    v.rst = rst; v.stl = stl; v.ac = ac; v.op = op;
    v.st = st; v.dn = dn; v.il = il; v.bd = bd;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_step(logic rst, logic stl, logic [1:0] ac, logic [5:0] op);
    int nx;
    bit err;
    if (rst) begin
      m_st = 0; m_dn = 0; m_il = 0; m_bd = 0; m_cyc = 0; m_ins = 0;
      return;
    end
    m_cyc++;
    if (stl) begin
      m_dn = 0;
      return;
    end
    err = 0;
    nx  = 0;
    if (m_st >= NUM) begin
      err = 1; m_bd = 1;
    end else if (ac == 2'd0) begin
      nx = 0;
    end else if (ac == 2'd3) begin
      nx = m_st + 1;
      if (nx >= NUM) begin nx = 0; err = 1; m_bd = 1; end
    end else if (ac == 2'd1) begin
      if (d1.exists(int'(op))) nx = d1[int'(op)];
      else begin err = 1; m_il = 1; end
    end else begin
      if (d2.exists(int'(op))) nx = d2[int'(op)];
      else begin err = 1; m_il = 1; end
    end
    m_dn = (m_st != 0) && (nx == 0) && !err;
    if (m_dn) m_ins++;
    m_st = nx;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic drive(logic rst, logic stl, logic [1:0] ac, logic [5:0] op);
    reset = rst; stall = stl; addrctl = ac; opcode = op;
    @(posedge clk);
    model_step(rst, stl, ac, op);
    @(negedge clk);
  endtask

  task automatic chk_model(string tag);
    chk({tag, " state"}, int'(state), m_st);
    chk({tag, " instr_done"}, int'(instr_done), int'(m_dn));
    chk({tag, " illegal_op"}, int'(illegal_op), int'(m_il));
    chk({tag, " bad_state"}, int'(bad_state), int'(m_bd));
`ifdef USEQ_PERF_EN
    chk({tag, " cycle_cnt"}, int'(cycle_cnt), m_cyc % (1 << CW));
    chk({tag, " instr_cnt"}, int'(instr_cnt), m_ins % (1 << CW));
`endif
  endtask

  initial begin
    logic [5:0] ops [6];
    d1[0] = 6; d1[35] = 2; d1[43] = 2; d1[4] = 8; d1[2] = 9;
    d2[35] = 3; d2[43] = 5;
    ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43;
    ops[3] = 6'd4; ops[4] = 6'd2;  ops[5] = 6'd15;

    // rst stl ac op | state done ill bad
    add(1, 0, 2'b00, 6'h00, 0, 0, 0, 0);
    // lw
    add(0, 0, 2'b11, 6'h00, 1, 0, 0, 0);
    add(0, 0, 2'b01, 6'h23, 2, 0, 0, 0);
    add(0, 0, 2'b10, 6'h23, 3, 0, 0, 0);
    add(0, 0, 2'b11, 6'h00, 4, 0, 0, 0);
    add(0, 0, 2'b00, 6'h00, 0, 1, 0, 0);
    // sw
    add(0, 0, 2'b11, 6'h2B, 1, 0, 0, 0);
    add(0, 0, 2'b01, 6'h2B, 2, 0, 0, 0);
    add(0, 0, 2'b10, 6'h2B, 5, 0, 0, 0);
    add(0, 0, 2'b00, 6'h00, 0, 1, 0, 0);
    // beq, then fetch while already in fetch
    add(0, 0, 2'b11, 6'h04, 1, 0, 0, 0);
    add(0, 0, 2'b01, 6'h04, 8, 0, 0, 0);
    add(0, 0, 2'b00, 6'h00, 0, 1, 0, 0);
    add(0, 0, 2'b00, 6'h00, 0, 0, 0, 0);
    // lw with a 4-cycle stall in state 3
    add(0, 0, 2'b11, 6'h23, 1, 0, 0, 0);
    add(0, 0, 2'b01, 6'h23, 2, 0, 0, 0);
    add(0, 0, 2'b10, 6'h23, 3, 0, 0, 0);
    add(0, 1, 2'b11, 6'h00, 3, 0, 0, 0);
    add(0, 1, 2'b11, 6'h3F, 3, 0, 0, 0);
    add(0, 1, 2'b11, 6'h00, 3, 0, 0, 0);
    add(0, 1, 2'b00, 6'h00, 3, 0, 0, 0);
    add(0, 0, 2'b11, 6'h00, 4, 0, 0, 0);
    add(0, 0, 2'b00, 6'h00, 0, 1, 0, 0);
    // sequential overflow from state 9
    add(0, 0, 2'b11, 6'h02, 1, 0, 0, 0);
    add(0, 0, 2'b01, 6'h02, 9, 0, 0, 0);
    add(0, 0, 2'b11, 6'h00, 0, 0, 0, 1);
    add(0, 0, 2'b11, 6'h00, 1, 0, 0, 1);
    add(0, 0, 2'b01, 6'h00, 6, 0, 0, 1);
    // reset together with stall in state 6
    add(1, 1, 2'b11, 6'h00, 0, 0, 0, 0);
    // illegal opcode, then an R-type with the flag held
    add(0, 0, 2'b11, 6'h0F, 1, 0, 0, 0);
    add(0, 0, 2'b01, 6'h0F, 0, 0, 1, 0);
    add(0, 0, 2'b11, 6'h00, 1, 0, 1, 0);
    add(0, 0, 2'b01, 6'h00, 6, 0, 1, 0);
    add(0, 0, 2'b11, 6'h00, 7, 0, 1, 0);
    add(0, 0, 2'b00, 6'h00, 0, 1, 1, 0);
    // dispatch-2 miss
    add(0, 0, 2'b11, 6'h04, 1, 0, 1, 0);
    add(0, 0, 2'b10, 6'h04, 0, 0, 1, 0);
    add(1, 0, 2'b00, 6'h00, 0, 0, 0, 0);
    add(0, 0, 2'b11, 6'h00, 1, 0, 0, 0);
    add(0, 0, 2'b10, 6'h00, 0, 0, 1, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].ac, tbl[i].op);
      chk($sformatf("vec%0d state", i), int'(state), tbl[i].st);
      chk($sformatf("vec%0d instr_done", i), int'(instr_done), int'(tbl[i].dn));
      chk($sformatf("vec%0d illegal_op", i), int'(illegal_op), int'(tbl[i].il));
      chk($sformatf("vec%0d bad_state", i), int'(bad_state), int'(tbl[i].bd));
    end

`ifdef USEQ_PERF_EN
    // 17 jump instructions, 3 cycles each
    drive(1, 0, 2'b00, 6'h00);
    for (int k = 0; k < 17; k++) begin
      drive(0, 0, 2'b11, 6'h02);
      drive(0, 0, 2'b01, 6'h02);
      drive(0, 0, 2'b00, 6'h00);
    end
    chk("j17 instr_cnt", int'(instr_cnt), 1);
    chk("j17 cycle_cnt", int'(cycle_cnt), 3);
    chk("j17 instr_done", int'(instr_done), 1);
    // stall window: 5 cycles counted across 4 stalled + 1 released
    drive(1, 0, 2'b00, 6'h00);
    drive(0, 0, 2'b11, 6'h23);
    drive(0, 0, 2'b01, 6'h23);
    drive(0, 0, 2'b10, 6'h23);
    chk("stallwin start cycle_cnt", int'(cycle_cnt), 3);
    for (int k = 0; k < 4; k++) drive(0, 1, 2'b11, 6'h00);
    drive(0, 0, 2'b11, 6'h00);
    chk("stallwin end cycle_cnt", int'(cycle_cnt), 8);
    chk("stallwin end state", int'(state), 4);
`endif

    // randomized run against the reference model
    for (int n = 0; n < 1500; n++) begin
      logic       r, s;
      logic [1:0] a;
      logic [5:0] o;
      r = ($urandom_range(0, 79) == 0);
      s = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) o = 6'($urandom_range(0, 63));
      else o = ops[$urandom_range(0, 5)];
      drive(r, s, a, o);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
